// File: rtl/registro_eventos.sv
// Timestamped pattern-event logger: FIFO of {mask,par,ts}, 1-cycle write latency, show-ahead read; full FIFO drops events unless popped that cycle.
// Optional per-pattern saturating counters are built only when REGISTRO_CONTADORES_EN is defined (otherwise tied to 0).
module registro_eventos #(
    parameter int TS_W       = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_A,
    input  logic                  in_B,
    input  logic                  in_C,
    input  logic [3:0]            in_par,
    input  logic                  rd_en,
    input  logic                  clr,
    output logic [7+TS_W-1:0]     dato_out,
    output logic                  vacio,
    output logic                  lleno,
    output logic [DEPTH_LOG2:0]   nivel,
    output logic                  desborde,
    output logic [CNT_W-1:0]      cnt_A,
    output logic [CNT_W-1:0]      cnt_B,
    output logic [CNT_W-1:0]      cnt_C
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam int                REC_W   = 7 + TS_W;
    localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [TS_W-1:0]        r_ts;
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_nivel;
    logic                   r_vacio;
    logic                   r_lleno;
    logic                   r_desborde;
    logic [REC_W-1:0]       r_mem [DEPTH];

    logic                   w_ev;
    logic                   w_rd;
    logic                   w_wr;
    logic [REC_W-1:0]       w_rec;
    logic [DEPTH_LOG2:0]    w_nivel_nxt;

    assign w_ev  = in_A | in_B | in_C;
    assign w_rd  = rd_en & ~r_vacio;
    // A full FIFO still accepts the new record when the head is popped in the same cycle.
    assign w_wr  = w_ev & (~r_lleno | w_rd);
    assign w_rec = {in_C, in_B, in_A, in_par, r_ts};

    always_comb begin
        w_nivel_nxt = r_nivel;
        if (w_wr && !w_rd)
            w_nivel_nxt = r_nivel + 1'b1;
        else if (w_rd && !w_wr)
            w_nivel_nxt = r_nivel - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_nivel    <= '0;
            r_vacio    <= 1'b1;
            r_lleno    <= 1'b0;
            r_desborde <= 1'b0;
        end else begin
            r_ts    <= r_ts + 1'b1;
            r_nivel <= w_nivel_nxt;
            r_vacio <= (w_nivel_nxt == '0);
            r_lleno <= (w_nivel_nxt == LP_FULL);
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (clr)
                r_desborde <= 1'b0;
            else if (w_ev && !w_wr)
                r_desborde <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_rec;
    end

    // Storage is not reset, so the head is masked while empty.
    assign dato_out = r_vacio ? '0 : r_mem[r_rd_ptr];
    assign vacio    = r_vacio;
    assign lleno    = r_lleno;
    assign nivel    = r_nivel;
    assign desborde = r_desborde;

`ifdef REGISTRO_CONTADORES_EN
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       w_flag;

    assign w_flag = {in_C, in_B, in_A};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++)
                r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (clr)
                    r_cnt[k] <= '0;
                else if (w_flag[k] && (r_cnt[k] != '1))
                    r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    assign cnt_A = r_cnt[0];
    assign cnt_B = r_cnt[1];
    assign cnt_C = r_cnt[2];
`else
    assign cnt_A = '0;
    assign cnt_B = '0;
    assign cnt_C = '0;
`endif

endmodule

// File: tb/tb_registro_eventos.sv
// Bench for registro_eventos: directed stimulus pushes expected records, a negedge monitor pops them on every read.
module tb_registro_eventos;

`ifdef REGISTRO_CONTADORES_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_A, in_B, in_C, rd_en, clr;
    logic [3:0]  in_par;
    logic [14:0] dato_out;
    logic        vacio, lleno, desborde;
    logic [3:0]  nivel;
    logic [7:0]  cnt_A, cnt_B, cnt_C;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [14:0] exp_q[$];
    logic [7:0]  tb_ts;
    int          m_lvl = 0;
    bit          m_ovf = 0;
    int          m_ca = 0, m_cb = 0, m_cc = 0;

    registro_eventos dut (
        .clk(clk), .rst_n(rst_n), .in_A(in_A), .in_B(in_B), .in_C(in_C),
        .in_par(in_par), .rd_en(rd_en), .clr(clr), .dato_out(dato_out),
        .vacio(vacio), .lleno(lleno), .nivel(nivel), .desborde(desborde),
        .cnt_A(cnt_A), .cnt_B(cnt_B), .cnt_C(cnt_C)
    );

    always #5 clk = ~clk;

    // Reference timestamp: value of the cycle that the next rising edge samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 8'd0;
        else        tb_ts <= tb_ts + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CEN ? 32'(v) : 32'd0;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_en === 1'b1 && vacio === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(dato_out), 32'h7fff_ffff);
            end else begin
                chk("pop_record", 32'(dato_out), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drive one cycle (at posedge+1), update the reference model, return at the next posedge+1.
    task automatic step(input logic a, b, c, input logic [3:0] p, input logic rd, cl);
        bit ev, mrd, mwr;
        in_A = a; in_B = b; in_C = c; in_par = p; rd_en = rd; clr = cl;
        ev  = a | b | c;
        mrd = rd && (m_lvl != 0);
        mwr = ev && ((m_lvl < 8) || mrd);
        if (mwr) exp_q.push_back({c, b, a, p, tb_ts});
        if (cl)       m_ovf = 0;
        else if (ev && !mwr) m_ovf = 1;
        if (mwr && !mrd) m_lvl++;
        else if (mrd && !mwr) m_lvl--;
        if (cl) begin
            m_ca = 0; m_cb = 0; m_cc = 0;
        end else begin
            if (a && m_ca < 255) m_ca++;
            if (b && m_cb < 255) m_cb++;
            if (c && m_cc < 255) m_cc++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        in_A = 0; in_B = 0; in_C = 0; in_par = 4'h0; rd_en = 0; clr = 0;
    endtask

    task automatic drain();
        while (m_lvl > 0) step(0, 0, 0, 4'h0, 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_A = 0; in_B = 0; in_C = 0; in_par = 4'h0; rd_en = 0; clr = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_vacio",    32'(vacio),    32'd1);
        chk("rst_lleno",    32'(lleno),    32'd0);
        chk("rst_nivel",    32'(nivel),    32'd0);
        chk("rst_dato",     32'(dato_out), 32'd0);
        chk("rst_desborde", 32'(desborde), 32'd0);
        chk("rst_cnt_A",    32'(cnt_A),    32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Single B event at ts=5, visible after its edge, then popped.
        repeat (5) step(0, 0, 0, 4'h0, 0, 0);
        step(0, 1, 0, 4'b1100, 0, 0);
        chk("t1_dato",  32'(dato_out), 32'(15'b010_1100_00000101));
        chk("t1_nivel", 32'(nivel),    32'd1);
        chk("t1_vacio", 32'(vacio),    32'd0);
        step(0, 0, 0, 4'h0, 1, 0);
        chk("t1_vacio_after", 32'(vacio),    32'd1);
        chk("t1_dato_after",  32'(dato_out), 32'd0);

        // A and C together make one record with mask 101.
        step(0, 0, 0, 4'h0, 0, 1);
        step(1, 0, 1, 4'h3, 0, 0);
        chk("t2_mask",  32'(dato_out[14:12]), 32'(3'b101));
        chk("t2_nivel", 32'(nivel), 32'd1);
        chk("t2_cnt_A", 32'(cnt_A), cexp(1));
        chk("t2_cnt_B", 32'(cnt_B), cexp(0));
        chk("t2_cnt_C", 32'(cnt_C), cexp(1));
        drain();

        // Fill, overflow, clear, then simultaneous push/pop on full.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 4'(i), 0, 0);
        chk("t3_lleno", 32'(lleno), 32'd1);
        chk("t3_nivel", 32'(nivel), 32'd8);
        chk("t3_desborde_pre", 32'(desborde), 32'd0);
        step(0, 1, 0, 4'h9, 0, 0);
        chk("t3_desborde", 32'(desborde), 32'd1);
        chk("t3_nivel_drop", 32'(nivel), 32'd8);
        step(0, 0, 0, 4'h0, 0, 1);
        chk("t3_clr", 32'(desborde), 32'd0);
        step(0, 0, 1, 4'hA, 1, 0);
        chk("t4_nivel",    32'(nivel),    32'd8);
        chk("t4_lleno",    32'(lleno),    32'd1);
        chk("t4_desborde", 32'(desborde), 32'd0);
        step(1, 0, 0, 4'hB, 0, 1);
        chk("clr_beats_drop", 32'(desborde), 32'd0);
        chk("clr_beats_flag", 32'(cnt_A),    32'd0);
        chk("model_ovf",      32'(desborde), 32'(m_ovf));
        drain();
        chk("t4_vacio", 32'(vacio), 32'd1);

        // Long A run with concurrent reads: counter saturation and timestamp wrap.
        for (int i = 0; i < 300; i++) step(1, 0, 0, 4'(i), 1, 0);
        chk("t5_cnt_A", 32'(cnt_A), cexp(255));
        chk("t5_nivel", 32'(nivel), 32'd1);
        drain();

        // Asynchronous reset with five records stored.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(i), 0, 0);
        chk("t6_nivel_pre", 32'(nivel), 32'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_nivel", 32'(nivel), 32'd0);
        chk("t6_vacio", 32'(vacio), 32'd1);
        chk("t6_cnt_C", 32'(cnt_C), 32'd0);
        chk("t6_dato",  32'(dato_out), 32'd0);
        exp_q.delete();
        m_lvl = 0; m_ovf = 0; m_ca = 0; m_cb = 0; m_cc = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        step(1, 0, 0, 4'h6, 0, 0);
        chk("t6_first_ts", 32'(dato_out), 32'(15'b001_0110_00000000));
        chk("t6_cnt_A",    32'(cnt_A),    cexp(1));
        drain();

        chk("final_vacio",   32'(vacio),         32'd1);
        chk("final_q_empty", 32'(exp_q.size()),  32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
